// File: rtl/parity_tx.sv
// parity_tx: framed, LSB-first serial transmitter with parity generation.
// Frame: start(0), 8 data bits LSB first, optional parity bit, stop(1);
// each bit lasts CLKS_PER_BIT clocks. All outputs come from flops.
// Optional feature macro: PARITY_EN. When it is defined, the parity bit is
// sent and par holds the computed parity. When it is undefined, the frame is
// 10 bits, odd_sel is ignored and par is tied low.
module parity_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    input  logic       odd_sel,
    output logic       tx,
    output logic       ready,
    output logic       done,
    output logic       par
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_tx, w_tx_nxt;
    logic          r_ready, w_ready_nxt;
    logic          r_done, w_done_nxt;
    logic          w_cnt_last;
    logic          w_par_cur;
`ifdef PARITY_EN
    logic          r_par, w_par_nxt;
`else
    logic          w_unused_odd_sel;
    assign w_unused_odd_sel = odd_sel;
`endif

    assign w_cnt_last = (r_cnt == CNT_MAX);

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
`ifdef PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
`ifdef PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    // Next-state, counter and datapath updates; outputs are decoded from the
    // next state so they land in flops aligned with the state they describe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
`ifdef PARITY_EN
        w_par_nxt   = r_par;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_shift_nxt = data;
`ifdef PARITY_EN
                    w_par_nxt   = odd_sel ? ~(^data) : (^data);
`endif
                end
            end
            S_START: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_bit == 3'd7) begin
`ifdef PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`ifdef PARITY_EN
            S_PARITY: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_STOP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

`ifdef PARITY_EN
        w_par_cur = w_par_nxt;
`else
        w_par_cur = 1'b0;
`endif
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_done_nxt  = (w_state_nxt == S_STOP) && (w_cnt_nxt == CNT_MAX);
        unique case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef PARITY_EN
            S_PARITY: w_tx_nxt = w_par_cur;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign tx    = r_tx;
    assign ready = r_ready;
    assign done  = r_done;
`ifdef PARITY_EN
    assign par   = r_par;
`else
    assign par   = 1'b0;
`endif

endmodule

// File: tb/tb_parity_tx.sv
// tb_parity_tx: directed bench for parity_tx. Three instances cover
// CLKS_PER_BIT = 4, 1 and 2; the expected frame layout follows the build's
// PARITY_EN setting.
module tb_parity_tx;

`ifdef PARITY_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif
    localparam int NB = PE ? 11 : 10;

    logic       clk = 1'b0;
    logic [2:0] rst_v;
    logic [2:0] start_v;
    logic [2:0] odd_v;
    logic [7:0] data_v [3];
    wire  [2:0] tx_v, rdy_v, done_v, par_v;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    parity_tx #(.CLKS_PER_BIT(4)) u_n4 (
        .clk(clk), .rst(rst_v[0]), .data(data_v[0]), .start(start_v[0]),
        .odd_sel(odd_v[0]), .tx(tx_v[0]), .ready(rdy_v[0]), .done(done_v[0]),
        .par(par_v[0]));
    parity_tx #(.CLKS_PER_BIT(1)) u_n1 (
        .clk(clk), .rst(rst_v[1]), .data(data_v[1]), .start(start_v[1]),
        .odd_sel(odd_v[1]), .tx(tx_v[1]), .ready(rdy_v[1]), .done(done_v[1]),
        .par(par_v[1]));
    parity_tx #(.CLKS_PER_BIT(2)) u_n2 (
        .clk(clk), .rst(rst_v[2]), .data(data_v[2]), .start(start_v[2]),
        .odd_sel(odd_v[2]), .tx(tx_v[2]), .ready(rdy_v[2]), .done(done_v[2]),
        .par(par_v[2]));

    function automatic int nper(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge with the instance idle. Accepts one frame on
    // the next rising edge and checks every cycle of it plus the idle cycle.
    task automatic send_frame(input int k, input logic [7:0] d, input logic odd,
                              input logic ep, input bit hold);
        int   n;
        int   b;
        logic etx;
        n = nper(k);
        check($sformatf("k%0d pre_ready", k), 32'(rdy_v[k]), 32'd1);
        data_v[k]  = d;
        odd_v[k]   = odd;
        start_v[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            data_v[k] = ~d;
            odd_v[k]  = ~odd;
        end else begin
            start_v[k] = 1'b0;
        end
        check($sformatf("k%0d d%0h par", k, d), 32'(par_v[k]), 32'(ep));
        for (int c = 0; c < NB * n; c++) begin
            b = c / n;
            if (b == 0)            etx = 1'b0;
            else if (b <= 8)       etx = d[b-1];
            else if (b == 9 && PE) etx = ep;
            else                   etx = 1'b1;
            check($sformatf("k%0d d%0h tx c%0d", k, d, c), 32'(tx_v[k]), 32'(etx));
            check($sformatf("k%0d d%0h done c%0d", k, d, c), 32'(done_v[k]),
                  32'(c == NB * n - 1));
            check($sformatf("k%0d d%0h ready c%0d", k, d, c), 32'(rdy_v[k]), 32'd0);
            @(negedge clk);
        end
        check($sformatf("k%0d d%0h end_ready", k, d), 32'(rdy_v[k]), 32'd1);
        check($sformatf("k%0d d%0h end_tx", k, d), 32'(tx_v[k]), 32'd1);
        check($sformatf("k%0d d%0h end_done", k, d), 32'(done_v[k]), 32'd0);
        check($sformatf("k%0d d%0h end_par", k, d), 32'(par_v[k]), 32'(ep));
    endtask

    initial begin
        bit saw_done;
        rst_v   = 3'b111;
        start_v = 3'b000;
        odd_v   = 3'b000;
        for (int i = 0; i < 3; i++) data_v[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("k%0d rst tx", k), 32'(tx_v[k]), 32'd1);
            check($sformatf("k%0d rst ready", k), 32'(rdy_v[k]), 32'd1);
            check($sformatf("k%0d rst done", k), 32'(done_v[k]), 32'd0);
            check($sformatf("k%0d rst par", k), 32'(par_v[k]), 32'd0);
        end
        rst_v = 3'b000;
        @(negedge clk);

        // N=4: A5 even (par 0), A5 odd (par 1), 07 even (par 1), back to back.
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'hA5, 1'b1, PE & 1'b1, 1'b0);
        send_frame(0, 8'h07, 1'b0, PE & 1'b1, 1'b0);

        // N=1: start held high; FF accepted at edge 0, 00 at the first idle edge.
        send_frame(1, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(1, 8'h00, 1'b1, PE & 1'b1, 1'b0);

        // N=2: 3C, even parity.
        send_frame(2, 8'h3C, 1'b0, 1'b0, 1'b0);

        // N=4: reset in cycle 20 of a frame aborts it cleanly.
        data_v[0]  = 8'hA5;
        odd_v[0]   = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("abort pre tx", 32'(tx_v[0]), 32'd0);
        check("abort pre ready", 32'(rdy_v[0]), 32'd0);
        rst_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort tx", 32'(tx_v[0]), 32'd1);
        check("abort ready", 32'(rdy_v[0]), 32'd1);
        check("abort done", 32'(done_v[0]), 32'd0);
        check("abort par", 32'(par_v[0]), 32'd0);
        rst_v[0] = 1'b0;
        saw_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done_v[0]) saw_done = 1'b1;
        end
        check("abort no_done", 32'(saw_done), 32'd0);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);

        // N=4: rst and start on the same edge; reset wins.
        rst_v[0]   = 1'b1;
        start_v[0] = 1'b1;
        data_v[0]  = 8'h07;
        @(posedge clk);
        @(negedge clk);
        check("rst_start ready", 32'(rdy_v[0]), 32'd1);
        check("rst_start tx", 32'(tx_v[0]), 32'd1);
        rst_v[0]   = 1'b0;
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_start idle_ready", 32'(rdy_v[0]), 32'd1);
        check("rst_start idle_tx", 32'(tx_v[0]), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
